regime_scan_ctrl: RTL and testbench
===================================

Name: regime_scan_ctrl

Overview:
- Multi-cycle sequencer that measures the leading run of a chosen bit value (0 or 1) in an N-bit posit word, CHUNK bits per cycle.
- Wraps one narrow leading-run counter of CHUNK bits. That counter is either an instance of the cls block with NUM_BITS=CHUNK plus an all-equal detect, or equivalent logic.
- Sits in the PPU decode path ahead of regime/exponent extraction, for area-constrained builds where a full-width count is too large.
- Valid/ready handshake on both the input and output sides.

Parameters:
- N, 16, posit word width. Must be an integer multiple of CHUNK and at least 2*CHUNK.
- CHUNK, 4, bits examined per scan cycle; a power of two, at least 2.
- NCH, N/CHUNK (derived), number of chunks.
- W, $clog2(N+1) (derived), width of the run-length result.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a word is offered.
- in_ready  output  1  block can accept a word.
- bits  input  N  word to scan; MSB is scanned first.
- val  input  1  bit value whose leading run is counted.
- flush  input  1  synchronous abort; discards the in-flight word or result.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- run_len  output  W  count of consecutive val bits from the MSB, range 0..N.
- all_set  output  1  run_len == N.
- scan_cycles  output  $clog2(NCH+1)  number of SCAN cycles used for this result (performance monitor).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - in_ready=0 while reset is held, 1 after release.
  - out_valid=0, run_len=0, all_set=0, scan_cycles=0.
  - Shift register and chunk index cleared.
- States: IDLE, SCAN, DONE. Encoding is free.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture bits into shift register sh and val into v_q; cnt=0; chunk index ci=0; go to SCAN.
- SCAN, one cycle per chunk:
  - in_ready=0.
  - c = sh[N-1:N-CHUNK]; r = leading run of v_q in c, range 0..CHUNK.
  - If r==CHUNK and ci!=NCH-1: cnt+=CHUNK, sh<<=CHUNK, ci++, stay in SCAN.
  - Otherwise (run terminated or last chunk): cnt+=r, go to DONE.
  - Early termination: the scan stops at the first chunk containing a bit != v_q.
- DONE:
  - out_valid=1; run_len=cnt; all_set=(cnt==N); scan_cycles=ci+1.
  - Outputs are held stable while out_ready=0.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
- Latency: accept edge to out_valid high is (k+1) cycles, where k = scan_cycles, range 1..NCH.
- Throughput without the optional feature: one word per k+2 cycles.
- Width rule: cnt is W bits and saturates naturally at N. Overflow is impossible, since at most NCH*CHUNK=N can be added.
- flush:
  - Any state goes to IDLE on the next edge; out_valid is forced to 0 that edge.
  - An input handshake in the same cycle is ignored; flush has priority.
  - run_len, all_set and scan_cycles keep their last values; they are don't-care while out_valid=0.
- bits and val are sampled only on the accept edge; later changes on them have no effect.
- in_valid is ignored outside IDLE, except in DONE with the optional feature.
- Reset mid-SCAN or mid-DONE: immediate return to reset values; no result is emitted.

Optional Feature:
- Macro REGIME_SCAN_BACK2BACK_EN.
- Defined:
  - In DONE, in_ready = out_ready && !flush.
  - If an output handshake and an input handshake occur in the same cycle, capture the new word and go directly to SCAN; no IDLE bubble.
  - Throughput becomes one word per k+1 cycles.
- Undefined: in_ready=0 in DONE; the FSM always passes through IDLE.

Test Plan:
- N=16, CHUNK=4, bits=16'hFFF0, val=1 -> run_len=12, all_set=0, scan_cycles=4, out_valid high 5 cycles after accept.
- bits=16'h0000, val=1 -> run_len=0, scan_cycles=1. Then bits=16'h3FFF, val=0 -> run_len=2, scan_cycles=1.
- bits=16'hFFFF, val=1 -> run_len=16, all_set=1, scan_cycles=4. Repeat with bits=16'h0000, val=0 -> same values.
- Backpressure: out_ready=0 for 6 cycles in DONE -> out_valid, run_len and all_set held constant, in_ready=0, a new in_valid is not accepted. Release -> one handshake, then IDLE.
- flush asserted in the 2nd SCAN cycle of bits=16'hFFF0 -> IDLE next edge, no out_valid. The next word 16'hFF00/val=1 -> run_len=8.
- rst_n pulsed low mid-SCAN -> outputs at reset values asynchronously. With REGIME_SCAN_BACK2BACK_EN: 4 back-to-back words, each with k=1 -> a result every 2 cycles, in_ready high in every DONE cycle where out_ready=1.

Source files
------------

// File: rtl/regime_scan_ctrl_if.sv
// Handshake bundle for regime_scan_ctrl: word/value input side, run-length result side.
// master = producer/consumer driving the scanner, slave = the scanner itself.
interface regime_scan_ctrl_if #(
    parameter int N     = 16,
    parameter int CHUNK = 4
);
    localparam int NCH = N / CHUNK;
    localparam int W   = $clog2(N + 1);
    localparam int SW  = $clog2(NCH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  bits;
    logic          val;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  run_len;
    logic          all_set;
    logic [SW-1:0] scan_cycles;

    modport master (
        output in_valid, bits, val, flush, out_ready,
        input  in_ready, out_valid, run_len, all_set, scan_cycles
    );

    modport slave (
        input  in_valid, bits, val, flush, out_ready,
        output in_ready, out_valid, run_len, all_set, scan_cycles
    );
endinterface

// File: rtl/regime_scan_ctrl.sv
// Multi-cycle leading-run counter for posit regime decode, CHUNK bits per SCAN cycle.
// Define REGIME_SCAN_BACK2BACK_EN to accept the next word in DONE and skip the IDLE bubble.
module regime_scan_ctrl #(
    parameter int N     = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    regime_scan_ctrl_if.slave bus
);
    localparam int NCH = N / CHUNK;
    localparam int W   = $clog2(N + 1);
    localparam int SW  = $clog2(NCH + 1);
    localparam int CW  = $clog2(CHUNK + 1);
    localparam int CIW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_d;

    logic [N-1:0]   sh;
    logic           v_q;
    logic [W-1:0]   cnt;
    logic [CIW-1:0] ci;
    logic [W-1:0]   run_len_q;
    logic           all_set_q;
    logic [SW-1:0]  scan_cycles_q;

    logic [CHUNK-1:0] match;
    logic [CW-1:0]    r;
    logic             run_open;
    logic [W-1:0]     cnt_end;
    logic             last_chunk;
    logic             scan_more;
    logic             scan_end;
    logic             load;

    // Bits equal to v_q become 1, so the run is the count of leading ones in match.
    always_comb begin
        match    = sh[N-1 -: CHUNK] ^ {CHUNK{~v_q}};
        r        = '0;
        run_open = 1'b1;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (run_open && match[i]) begin
                r = r + CW'(1);
            end else begin
                run_open = 1'b0;
            end
        end
    end

    assign last_chunk = (ci == CIW'(NCH - 1));
    assign scan_more  = (state == SCAN) && (r == CW'(CHUNK)) && !last_chunk;
    assign scan_end   = (state == SCAN) && !scan_more;
    assign cnt_end    = cnt + W'(r);
    assign load       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // in_ready is held low while reset is asserted even though state already reads IDLE.
    always_comb begin
        state_d       = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = (state == DONE);

        if (rst_n) begin
            case (state)
                IDLE:    bus.in_ready = 1'b1;
`ifdef REGIME_SCAN_BACK2BACK_EN
                DONE:    bus.in_ready = bus.out_ready && !bus.flush;
`endif
                default: bus.in_ready = 1'b0;
            endcase
        end

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (scan_end) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = load ? SCAN : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Result registers only move when a scan completes, so they stay frozen through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh            <= '0;
            v_q           <= 1'b0;
            cnt           <= '0;
            ci            <= '0;
            run_len_q     <= '0;
            all_set_q     <= 1'b0;
            scan_cycles_q <= '0;
        end else if (load) begin
            sh  <= bus.bits;
            v_q <= bus.val;
            cnt <= '0;
            ci  <= '0;
        end else if (!bus.flush && scan_more) begin
            cnt <= cnt + W'(CHUNK);
            sh  <= sh << CHUNK;
            ci  <= ci + CIW'(1);
        end else if (!bus.flush && scan_end) begin
            cnt           <= cnt_end;
            run_len_q     <= cnt_end;
            all_set_q     <= (cnt_end == W'(N));
            scan_cycles_q <= SW'(ci) + SW'(1);
        end
    end

    assign bus.run_len     = run_len_q;
    assign bus.all_set     = all_set_q;
    assign bus.scan_cycles = scan_cycles_q;
endmodule

// File: tb/tb_regime_scan_ctrl.sv
// Directed bench for regime_scan_ctrl (N=16, CHUNK=4): vector table plus handshake corner sequences.
// Compile with REGIME_SCAN_BACK2BACK_EN to also exercise the back-to-back path.
module tb_regime_scan_ctrl;
    localparam int N     = 16;
    localparam int CHUNK = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regime_scan_ctrl_if #(.N(N), .CHUNK(CHUNK)) bus ();

    regime_scan_ctrl #(.N(N), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] bits;
        logic        val;
        int          exp_len;
        int          exp_all;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];
    int   check_count = 0;
    int   pass_count  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offers a word and returns #1 after the accept edge with inputs scrambled.
    task automatic applyStimulus(input logic [15:0] b, input logic v);
        int waited = 0;
        bus.bits     = b;
        bus.val      = v;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.bits     = 16'($urandom);
        bus.val      = ~v;
    endtask

    task automatic waitResult(input string name, output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) begin
            checkOutput({name, "_result_timeout"}, 0, 1);
        end
    endtask

    task automatic countStrayResults(input string name);
        int seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        checkOutput(name, seen, 0);
    endtask

    task automatic runVector(input string name, input logic [15:0] b, input logic v,
                             input int len, input int all, input int cyc);
        int lat;
        applyStimulus(b, v);
        checkOutput({name, "_in_ready_scan"}, bus.in_ready, 0);
        waitResult(name, lat);
        checkOutput({name, "_latency"}, lat, cyc + 1);
        checkOutput({name, "_run_len"}, bus.run_len, len);
        checkOutput({name, "_all_set"}, bus.all_set, all);
        checkOutput({name, "_scan_cycles"}, bus.scan_cycles, cyc);
        bus.out_ready = 1'b1;
        #1;
`ifndef REGIME_SCAN_BACK2BACK_EN
        checkOutput({name, "_in_ready_done"}, bus.in_ready, 0);
`endif
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({name, "_out_valid_drop"}, bus.out_valid, 0);
        checkOutput({name, "_in_ready_idle"}, bus.in_ready, 1);
    endtask

`ifdef REGIME_SCAN_BACK2BACK_EN
    // Four single-chunk words with out_ready held high: one result every two cycles.
    task automatic runBackToBack();
        logic [15:0] wb[4];
        logic        wv[4];
        int          wl[4];
        wb[0] = 16'h0000; wv[0] = 1'b1; wl[0] = 0;
        wb[1] = 16'h8000; wv[1] = 1'b1; wl[1] = 1;
        wb[2] = 16'h3FFF; wv[2] = 1'b0; wl[2] = 2;
        wb[3] = 16'hE000; wv[3] = 1'b1; wl[3] = 3;
        bus.out_ready = 1'b1;
        bus.bits      = wb[0];
        bus.val       = wv[0];
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("b2b%0d_scan_quiet", i), bus.out_valid, 0);
            if (i < 3) begin
                bus.bits = wb[i + 1];
                bus.val  = wv[i + 1];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b%0d_out_valid", i), bus.out_valid, 1);
            checkOutput($sformatf("b2b%0d_run_len", i), bus.run_len, wl[i]);
            checkOutput($sformatf("b2b%0d_scan_cycles", i), bus.scan_cycles, 1);
            checkOutput($sformatf("b2b%0d_in_ready", i), bus.in_ready, 1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        checkOutput("b2b_end_out_valid", bus.out_valid, 0);
        checkOutput("b2b_end_in_ready", bus.in_ready, 1);
    endtask
`endif

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.bits      = '0;
        bus.val       = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'hFFF0, 1'b1, 12, 0, 4};
        vecs[1] = '{16'h0000, 1'b1,  0, 0, 1};
        vecs[2] = '{16'h3FFF, 1'b0,  2, 0, 1};
        vecs[3] = '{16'hFFFF, 1'b1, 16, 1, 4};
        vecs[4] = '{16'h0000, 1'b0, 16, 1, 4};
        vecs[5] = '{16'hFF00, 1'b1,  8, 0, 3};
        vecs[6] = '{16'h8000, 1'b1,  1, 0, 1};
        vecs[7] = '{16'hF800, 1'b1,  5, 0, 2};
        vecs[8] = '{16'h0FFF, 1'b0,  4, 0, 2};
        vecs[9] = '{16'hFFFE, 1'b1, 15, 0, 4};

        #2;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_run_len", bus.run_len, 0);
        checkOutput("rst_all_set", bus.all_set, 0);
        checkOutput("rst_scan_cycles", bus.scan_cycles, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].bits, vecs[i].val,
                      vecs[i].exp_len, vecs[i].exp_all, vecs[i].exp_cyc);
        end

        // Backpressure: result held for six cycles while a new word is offered.
        applyStimulus(16'hFFF0, 1'b1);
        waitResult("bp", lat);
        bus.in_valid = 1'b1;
        bus.bits     = 16'h0000;
        bus.val      = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("bp%0d_out_valid", c), bus.out_valid, 1);
            checkOutput($sformatf("bp%0d_run_len", c), bus.run_len, 12);
            checkOutput($sformatf("bp%0d_all_set", c), bus.all_set, 0);
            checkOutput($sformatf("bp%0d_in_ready", c), bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("bp_release_out_valid", bus.out_valid, 0);
        checkOutput("bp_release_in_ready", bus.in_ready, 1);
        countStrayResults("bp_no_extra_result");

        // Flush in the second SCAN cycle.
        applyStimulus(16'hFFF0, 1'b1);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checkOutput("flush_scan_out_valid", bus.out_valid, 0);
        checkOutput("flush_scan_in_ready", bus.in_ready, 1);
        countStrayResults("flush_scan_no_result");
        runVector("after_flush", 16'hFF00, 1'b1, 8, 0, 3);

        // Flush wins over a simultaneous input handshake in IDLE.
        bus.in_valid = 1'b1;
        bus.bits     = 16'hFFFF;
        bus.val      = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_idle_in_ready", bus.in_ready, 1);
        countStrayResults("flush_idle_no_accept");

        // Flush in DONE discards the pending result.
        applyStimulus(16'hFF00, 1'b1);
        waitResult("flush_done", lat);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        checkOutput("flush_done_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_done_out_valid", bus.out_valid, 0);
        checkOutput("flush_done_in_ready", bus.in_ready, 1);
        countStrayResults("flush_done_no_result");

        // Asynchronous reset in the middle of a scan.
        applyStimulus(16'hFFFF, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_run_len", bus.run_len, 0);
        checkOutput("midrst_all_set", bus.all_set, 0);
        checkOutput("midrst_scan_cycles", bus.scan_cycles, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        countStrayResults("midrst_no_result");
        checkOutput("midrst_in_ready_after", bus.in_ready, 1);
        runVector("after_rst", 16'h0FFF, 1'b0, 4, 0, 2);

`ifdef REGIME_SCAN_BACK2BACK_EN
        runBackToBack();
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
